// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle MIPS datapath.
// Sequences FETCH -> DECODE -> execute/memory/writeback states, drives every
// datapath enable and mux select, stretches memory states on mem_ready and
// flags unknown opcodes with a sticky illegal_op.
// Optional feature macro: MC_RETIRE_CNT_EN enables the retired-instruction
// counter; when undefined instr_retired is tied to zero.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        ir_load,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_src,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXEC     = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t state_r;
  state_t state_next_s;
  logic   illegal_r;
  logic   illegal_set_s;

  // State register; reset wins over everything, abandoning any memory access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; opcode only matters in DECODE and MEMADR.
  always_comb begin
    state_next_s  = S_FETCH;
    illegal_set_s = 1'b0;
    case (state_r)
      S_FETCH:  state_next_s = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:      state_next_s = S_EXEC;
          OP_LW, OP_SW:  state_next_s = S_MEMADR;
          OP_BEQ:        state_next_s = S_BRANCH;
          OP_ADDI:       state_next_s = S_ADDIEXEC;
          OP_J:          state_next_s = S_JUMP;
          default: begin
            state_next_s  = S_FETCH;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_next_s = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_next_s = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next_s = S_FETCH;
      S_MEMWR:  state_next_s = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_next_s = S_ALUWB;
      S_ALUWB:  state_next_s = S_FETCH;
      S_BRANCH: state_next_s = S_FETCH;
      S_ADDIEXEC: state_next_s = S_ADDIWB;
      S_ADDIWB: state_next_s = S_FETCH;
      S_JUMP:   state_next_s = S_FETCH;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Sticky illegal-opcode flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else if (illegal_set_s) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  // Moore output decode from the state register; only ir_load/pc_write in FETCH follow mem_ready.
  always_comb begin
    ir_load       = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_src        = 2'b00;
    case (state_r)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_load   = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDIWB:   reg_write = 1'b1;
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: begin
        ir_load = 1'b0;
      end
    endcase
  end

  assign state      = state_r;
  assign illegal_op = illegal_r;

`ifdef MC_RETIRE_CNT_EN
  logic [31:0] retired_r;
  logic        retire_s;

  // An instruction retires on the edge leaving its final state.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire_s = 1'b1;
      S_MEMWR: retire_s = mem_ready;
      default: retire_s = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= 32'd0;
    end else if (retire_s) begin
      retired_r <= retired_r + 32'd1;
    end else begin
      retired_r <= retired_r;
    end
  end

  assign instr_retired = retired_r;
`else
  assign instr_retired = 32'd0;
`endif

endmodule
